// File: rtl/mag_stats_pkg.sv
// Shared constants and types for the magnitude window statistics stage.
// Window length is 2**WIN_LOG2; over-threshold counts need one extra bit to reach N.
package mag_stats_pkg;

   localparam int MAG_W        = 8;
   localparam int WIN_LOG2_DEF = 3;
   localparam int WIN_LOG2_MIN = 1;
   localparam int WIN_LOG2_MAX = 6;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   function automatic int over_w(input int winLog2);
      return winLog2 + 1;
   endfunction

endpackage

// File: rtl/mag_window_acc.sv
// Window accumulator: tracks count, sum, max, min and over-threshold count.
// Exposes the merged values of the current sample so the completing sample's result is ready at once.
module mag_window_acc
   import mag_stats_pkg::*;
#(
   parameter int WIN_LOG2 = WIN_LOG2_DEF
)
(
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_accept,
   input  logic                         i_flush,
   input  logic [MAG_W-1:0]             i_mag,
   input  logic [MAG_W-1:0]             i_thresh,
   output logic                         o_last,
   output logic                         o_done,
   output logic [MAG_W-1:0]             o_avg,
   output logic [MAG_W-1:0]             o_peak,
   output logic [MAG_W-1:0]             o_min,
   output logic [over_w(WIN_LOG2)-1:0]  o_over
);

   localparam int SUM_W  = MAG_W + WIN_LOG2;
   localparam int OVER_W = over_w(WIN_LOG2);
   localparam logic [WIN_LOG2-1:0] LAST = '1;

   if (WIN_LOG2 < WIN_LOG2_MIN || WIN_LOG2 > WIN_LOG2_MAX) begin : g_badWinLog2
      $error("mag_window_acc: WIN_LOG2 out of range");
   end

   logic [WIN_LOG2-1:0] r_cnt;
   logic [SUM_W-1:0]    r_sum;
   logic [MAG_W-1:0]    r_max;
   logic [MAG_W-1:0]    r_min;
   logic [OVER_W-1:0]   r_over;

   logic                w_first;
   logic [SUM_W-1:0]    w_sumNext;
   logic [MAG_W-1:0]    w_maxNext;
   logic [MAG_W-1:0]    w_minNext;
   logic [OVER_W-1:0]   w_overNext;

   assign w_first = (r_cnt == '0);

   // The first sample of a window replaces the registers instead of merging with the previous window
   always_comb begin
      w_sumNext  = w_first ? SUM_W'(i_mag) : r_sum + SUM_W'(i_mag);
      w_maxNext  = (w_first || i_mag > r_max) ? i_mag : r_max;
      w_minNext  = (w_first || i_mag < r_min) ? i_mag : r_min;
      w_overNext = (w_first ? '0 : r_over) + OVER_W'(i_mag > i_thresh);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_sum  <= '0;
         r_max  <= '0;
         r_min  <= '0;
         r_over <= '0;
      end else if (i_flush) begin
         r_cnt  <= '0;
         r_sum  <= '0;
         r_over <= '0;
      end else if (i_accept) begin
         r_cnt  <= r_cnt + 1'b1;
         r_sum  <= w_sumNext;
         r_max  <= w_maxNext;
         r_min  <= w_minNext;
         r_over <= w_overNext;
      end
   end

   assign o_last = (r_cnt == LAST);
   assign o_done = i_accept && o_last;
   assign o_avg  = w_sumNext[SUM_W-1:WIN_LOG2];
   assign o_peak = w_maxNext;
   assign o_min  = w_minNext;
   assign o_over = w_overNext;

endmodule

// File: rtl/mag_window_stats.sv
// Windowed statistics over the magnitude stream with a one-entry result slot.
// Only the window-completing sample can be stalled, and only when the slot cannot be drained that cycle.
module mag_window_stats
   import mag_stats_pkg::*;
#(
   parameter int WIN_LOG2 = WIN_LOG2_DEF
)
(
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [MAG_W-1:0]             i_mag_in,
   input  logic                         i_mag_valid,
   output logic                         o_mag_ready,
   input  logic [MAG_W-1:0]             i_thresh,
   input  logic                         i_flush,
   output logic                         o_res_valid,
   input  logic                         i_res_ready,
   output logic [MAG_W-1:0]             o_res_avg,
   output logic [MAG_W-1:0]             o_res_peak,
   output logic [MAG_W-1:0]             o_res_min,
   output logic [over_w(WIN_LOG2)-1:0]  o_res_over
);

   localparam int OVER_W = over_w(WIN_LOG2);

   slot_state_t         r_state;
   slot_state_t         w_stateNext;
   logic                w_accept;
   logic                w_last;
   logic                w_done;
   logic [MAG_W-1:0]    w_avg;
   logic [MAG_W-1:0]    w_peak;
   logic [MAG_W-1:0]    w_min;
   logic [OVER_W-1:0]   w_over;

   assign o_mag_ready = !i_flush && !(w_last && r_state == SLOT_FULL && !i_res_ready);
   assign w_accept    = i_mag_valid && o_mag_ready;
   assign o_res_valid = (r_state == SLOT_FULL);

   mag_window_acc #(.WIN_LOG2(WIN_LOG2)) u_acc (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_accept (w_accept),
      .i_flush  (i_flush),
      .i_mag    (i_mag_in),
      .i_thresh (i_thresh),
      .o_last   (w_last),
      .o_done   (w_done),
      .o_avg    (w_avg),
      .o_peak   (w_peak),
      .o_min    (w_min),
      .o_over   (w_over)
   );

   // A completing sample always (re)fills the slot, even when it is being drained the same cycle
   always_comb begin
      w_stateNext = r_state;
      if (w_done) begin
         w_stateNext = SLOT_FULL;
      end else if (r_state == SLOT_FULL && i_res_ready) begin
         w_stateNext = SLOT_EMPTY;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= SLOT_EMPTY;
         o_res_avg  <= '0;
         o_res_peak <= '0;
         o_res_min  <= '0;
         o_res_over <= '0;
      end else begin
         r_state <= w_stateNext;
         if (w_done) begin
            o_res_avg  <= w_avg;
            o_res_peak <= w_peak;
            o_res_min  <= w_min;
            o_res_over <= w_over;
         end
      end
   end

endmodule

// File: tb/tb_mag_window_stats.sv
// Self-checking bench for mag_window_stats with N=4, using a queue-based window model.
// Inputs change on the falling edge; outputs are checked on the falling edge after each rising edge.
module tb_mag_window_stats;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] magIn = '0;
   logic       magValid = 1'b0;
   logic       magReady;
   logic [7:0] thresh = '0;
   logic       flush = 1'b0;
   logic       resValid;
   logic       resReady = 1'b0;
   logic [7:0] resAvg;
   logic [7:0] resPeak;
   logic [7:0] resMin;
   logic [2:0] resOver;

   int total = 0;
   int bad = 0;

   int          winQ[$];
   int          thrQ[$];
   bit          mFull = 1'b0;
   logic [26:0] mRes = '0;
   bit          expReadyV;
   logic        sawReady;

   always #5 clk = ~clk;

   mag_window_stats #(.WIN_LOG2(2)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_mag_in    (magIn),
      .i_mag_valid (magValid),
      .o_mag_ready (magReady),
      .i_thresh    (thresh),
      .i_flush     (flush),
      .o_res_valid (resValid),
      .i_res_ready (resReady),
      .o_res_avg   (resAvg),
      .o_res_peak  (resPeak),
      .o_res_min   (resMin),
      .o_res_over  (resOver)
   );

   // Drives one cycle from a falling edge and advances the window model; ends on the next falling edge
   task automatic driveCycle(input bit v, input int m, input int t, input bit f, input bit rr);
      int sum, pk, mn, ov;
      bit accepted;
      magValid = v;
      magIn    = m[7:0];
      thresh   = t[7:0];
      flush    = f;
      resReady = rr;
      expReadyV = !f && !(winQ.size() == 3 && mFull && !rr);
      #1;
      sawReady = magReady;
      @(posedge clk);
      accepted = v && expReadyV;
      if (f) begin
         winQ.delete();
         thrQ.delete();
      end
      if (accepted) begin
         winQ.push_back(m);
         thrQ.push_back(t);
      end
      if (winQ.size() == 4) begin
         sum = 0; pk = 0; mn = 255; ov = 0;
         foreach (winQ[i]) begin
            sum += winQ[i];
            if (winQ[i] > pk) pk = winQ[i];
            if (winQ[i] < mn) mn = winQ[i];
            if (winQ[i] > thrQ[i]) ov++;
         end
         mRes  = {8'(sum / 4), 8'(pk), 8'(mn), 3'(ov)};
         mFull = 1'b1;
         winQ.delete();
         thrQ.delete();
      end else if (mFull && rr) begin
         mFull = 1'b0;
      end
      @(negedge clk);
      magValid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({resValid, resAvg, resPeak, resMin, resOver} !== 28'd0 || magReady !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_state: got v=%0b avg=%0d pk=%0d mn=%0d ov=%0d rdy=%0b, exp all 0 rdy=1",
                  resValid, resAvg, resPeak, resMin, resOver, magReady);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int smp[4] = '{10, 20, 30, 41};
      for (int i = 0; i < 4; i++) begin
         driveCycle(1'b1, smp[i], 25, 1'b0, 1'b1);
         total++;
         if (sawReady !== expReadyV || resValid !== mFull) begin
            bad++;
            $display("[TB] FAIL basic_step%0d: got rdy=%0b v=%0b, exp rdy=%0b v=%0b", i, sawReady, resValid, expReadyV, mFull);
         end
      end
      total++;
      if (resValid !== 1'b1 || resAvg !== 8'd25 || resPeak !== 8'd41 || resMin !== 8'd10 || resOver !== 3'd2) begin
         bad++;
         $display("[TB] FAIL basic_result: got v=%0b avg=%0d pk=%0d mn=%0d ov=%0d, exp 1/25/41/10/2",
                  resValid, resAvg, resPeak, resMin, resOver);
      end
   endtask

   task automatic test_backpressure();
      int smp[8];
      int idx = 0;
      int cyc = 0;
      int stalls = 0;
      bit rr;
      logic [26:0] held = mRes;
      for (int i = 0; i < 8; i++) smp[i] = $urandom_range(0, 255);
      while (idx < 8 && cyc < 40) begin
         rr = (stalls >= 3);
         driveCycle(1'b1, smp[idx], 100, 1'b0, rr);
         total++;
         if (sawReady !== expReadyV || resValid !== mFull ||
             (mFull && {resAvg, resPeak, resMin, resOver} !== mRes)) begin
            bad++;
            $display("[TB] FAIL backpressure_cyc%0d: got rdy=%0b v=%0b res=%h, exp rdy=%0b v=%0b res=%h",
                     cyc, sawReady, resValid, {resAvg, resPeak, resMin, resOver}, expReadyV, mFull, mRes);
         end
         if (expReadyV) begin
            idx++;
         end else begin
            stalls++;
            total++;
            if (sawReady !== 1'b0 || resValid !== 1'b1 || {resAvg, resPeak, resMin, resOver} !== held) begin
               bad++;
               $display("[TB] FAIL backpressure_hold: got rdy=%0b v=%0b res=%h, exp rdy=0 v=1 res=%h",
                        sawReady, resValid, {resAvg, resPeak, resMin, resOver}, held);
            end
         end
         cyc++;
      end
      total++;
      if (idx < 8 || stalls != 3) begin
         bad++;
         $display("[TB] FAIL backpressure_progress: got accepted=%0d stalls=%0d, exp 8 and 3", idx, stalls);
      end
   endtask

   task automatic test_extremes();
      for (int i = 0; i < 4; i++) driveCycle(1'b1, 255, 255, 1'b0, 1'b1);
      total++;
      if (resValid !== 1'b1 || resAvg !== 8'd255 || resPeak !== 8'd255 || resMin !== 8'd255 || resOver !== 3'd0) begin
         bad++;
         $display("[TB] FAIL extremes: got v=%0b avg=%0d pk=%0d mn=%0d ov=%0d, exp 1/255/255/255/0",
                  resValid, resAvg, resPeak, resMin, resOver);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) driveCycle(1'b1, 9 + i, 5, 1'b0, 1'b1);
      driveCycle(1'b1, 77, 5, 1'b1, 1'b1);
      total++;
      if (sawReady !== 1'b0 || resValid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL flush_cycle: got rdy=%0b v=%0b, exp rdy=0 v=0", sawReady, resValid);
      end
      for (int i = 0; i < 4; i++) driveCycle(1'b1, 5, 5, 1'b0, 1'b1);
      total++;
      if (resValid !== 1'b1 || resAvg !== 8'd5 || resPeak !== 8'd5 || resMin !== 8'd5 || resOver !== 3'd0) begin
         bad++;
         $display("[TB] FAIL flush_after: got v=%0b avg=%0d pk=%0d mn=%0d ov=%0d, exp 1/5/5/5/0",
                  resValid, resAvg, resPeak, resMin, resOver);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 6; i++) driveCycle(1'b1, 60 + 10 * i, 80, 1'b0, (i == 0));
      #2;
      rst = 1'b1;
      #1;
      winQ.delete();
      thrQ.delete();
      mFull = 1'b0;
      total++;
      if ({resValid, resAvg, resPeak, resMin, resOver} !== 28'd0 || magReady !== 1'b1) begin
         bad++;
         $display("[TB] FAIL async_reset: got v=%0b avg=%0d pk=%0d mn=%0d ov=%0d rdy=%0b, exp all 0 rdy=1",
                  resValid, resAvg, resPeak, resMin, resOver, magReady);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) driveCycle(1'b1, 30 + i, 31, 1'b0, 1'b1);
      total++;
      if (resValid !== 1'b1 || {resAvg, resPeak, resMin, resOver} !== {8'd31, 8'd33, 8'd30, 3'd2}) begin
         bad++;
         $display("[TB] FAIL async_reset_fresh: got v=%0b res=%h, exp v=1 res=%h",
                  resValid, {resAvg, resPeak, resMin, resOver}, {8'd31, 8'd33, 8'd30, 3'd2});
      end
   endtask

   task automatic test_stale_min();
      int smp[8] = '{1, 2, 3, 4, 200, 100, 150, 250};
      for (int i = 0; i < 8; i++) driveCycle(1'b1, smp[i], 120, 1'b0, 1'b1);
      total++;
      if (resValid !== 1'b1 || resMin !== 8'd100 || resPeak !== 8'd250 || resAvg !== 8'd175 || resOver !== 3'd3) begin
         bad++;
         $display("[TB] FAIL stale_min: got v=%0b avg=%0d pk=%0d mn=%0d ov=%0d, exp 1/175/250/100/3",
                  resValid, resAvg, resPeak, resMin, resOver);
      end
   endtask

   task automatic test_random();
      bit v, f, rr;
      for (int cyc = 0; cyc < 400; cyc++) begin
         v  = ($urandom_range(0, 9) < 8);
         f  = ($urandom_range(0, 19) == 0);
         rr = ($urandom_range(0, 9) < 6);
         driveCycle(v, $urandom_range(0, 255), $urandom_range(0, 255), f, rr);
         total++;
         if (sawReady !== expReadyV || resValid !== mFull ||
             (mFull && {resAvg, resPeak, resMin, resOver} !== mRes)) begin
            bad++;
            $display("[TB] FAIL random_cyc%0d: got rdy=%0b v=%0b res=%h, exp rdy=%0b v=%0b res=%h",
                     cyc, sawReady, resValid, {resAvg, resPeak, resMin, resOver}, expReadyV, mFull, mRes);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_extremes();
      test_flush();
      test_async_reset();
      test_stale_min();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
